uart_tx_ctrl: RTL and testbench

Frame sequencer for the UART transmit path. It consumes the free-running one-cycle baud tick from the baud tick generator and serialises one byte per valid/ready handshake onto the tx line, LSB first, as start + data + optional parity + stop bits. It sits between the upstream byte source (FIFO or command logic) and the TX pin. All line transitions are aligned to baud ticks.

---
 rtl/uart_tx_ctrl.sv | 167 ++++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// UartTxCtrl (module uart_tx_ctrl)
//
// Frame sequencer for the UART transmit path. Accepts one word per
// valid/ready handshake and serialises it LSB first onto the tx line as
// start bit + DATA_BITS data bits + optional parity bit + STOP_BITS stop
// bits. Every line transition is aligned to the one-cycle baud tick that
// comes from the baud tick generator.
//
// Ports:
//   clk_i        system clock
//   rst_i        synchronous active-high reset; aborts any frame in flight
//   baud_tick_i  one-clock pulse per bit period
//   tx_data_i    word to send, captured on the accepting edge
//   tx_valid_i   upstream has a word
//   tx_ready_o   controller can accept (IDLE only)
//   tx_o         registered serial line, idles high
//   tx_busy_o    high in every state except IDLE
//   tx_done_o    one-clock pulse in the cycle whose tick ends the last stop bit
// ---------------------------------------------------------------------------
module uart_tx_ctrl #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 baud_tick_i,
    input  logic [DATA_BITS-1:0] tx_data_i,
    input  logic                 tx_valid_i,
    output logic                 tx_ready_o,
    output logic                 tx_o,
    output logic                 tx_busy_o,
    output logic                 tx_done_o
);

    localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START_WAIT,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    state_e               state_q, state_d;
    logic                 tx_q, tx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 stop_last;

    // True while sitting in the final stop bit, so the next tick ends the frame.
    assign stop_last = (STOP_BITS != 2) || stop_cnt_q;

    // State register plus the datapath registers that travel with it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            tx_q       <= 1'b1;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
        end
    end

    // Next-state logic. The shift register moves right once per data bit so
    // the next bit to drive is always shift_q[0]. A tick in the accept cycle
    // is deliberately ignored, which gives the START_WAIT gap before the
    // start bit.
    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (tx_valid_i) begin
                    shift_d    = tx_data_i;
                    parity_d   = (^tx_data_i) ^ (PARITY_ODD != 0);
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                    state_d    = START_WAIT;
                end
            end
            START_WAIT: begin
                if (baud_tick_i) begin
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_tick_i) begin
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (baud_tick_i) begin
                    if (bit_cnt_q < LAST_BIT) begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end else if (PARITY_EN != 0) begin
                        tx_d    = parity_q;
                        state_d = PARITY;
                    end else begin
                        tx_d       = 1'b1;
                        stop_cnt_d = 1'b0;
                        state_d    = STOP;
                    end
                end
            end
            PARITY: begin
                if (baud_tick_i) begin
                    tx_d       = 1'b1;
                    stop_cnt_d = 1'b0;
                    state_d    = STOP;
                end
            end
            STOP: begin
                if (baud_tick_i) begin
                    tx_d = 1'b1;
                    if (!stop_last) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from the state. tx_done is raised in the cycle whose
    // tick closes the last stop bit, while the FSM is still in STOP, so no
    // accept can coincide with it; it is masked during reset.
    always_comb begin
        tx_ready_o = (state_q == IDLE);
        tx_busy_o  = (state_q != IDLE);
        tx_done_o  = !rst_i && (state_q == STOP) && baud_tick_i && stop_last;
        tx_o       = tx_q;
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for uart_tx_ctrl. Four instances cover the default framing,
// even parity, odd parity and two stop bits. The baud tick fires once every
// 16 clocks. Inputs are driven and outputs sampled 2ns after each falling
// clock edge, well away from the rising edge the DUT uses.
// ---------------------------------------------------------------------------
module tb_uart_tx_ctrl;

    logic       clk;
    logic       rst;
    logic       baudTick;
    int         tickCnt;
    logic       validW [4];
    logic [7:0] dataW  [4];
    logic       txW    [4];
    logic       readyW [4];
    logic       busyW  [4];
    logic       doneW  [4];

    int testsRun;
    int testsFailed;

    // Unit 0: 8N1 defaults
    uart_tx_ctrl #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
        .clk_i(clk), .rst_i(rst), .baud_tick_i(baudTick),
        .tx_data_i(dataW[0]), .tx_valid_i(validW[0]),
        .tx_ready_o(readyW[0]), .tx_o(txW[0]), .tx_busy_o(busyW[0]), .tx_done_o(doneW[0])
    );

    // Unit 1: even parity
    uart_tx_ctrl #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (
        .clk_i(clk), .rst_i(rst), .baud_tick_i(baudTick),
        .tx_data_i(dataW[1]), .tx_valid_i(validW[1]),
        .tx_ready_o(readyW[1]), .tx_o(txW[1]), .tx_busy_o(busyW[1]), .tx_done_o(doneW[1])
    );

    // Unit 2: odd parity
    uart_tx_ctrl #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
        .clk_i(clk), .rst_i(rst), .baud_tick_i(baudTick),
        .tx_data_i(dataW[2]), .tx_valid_i(validW[2]),
        .tx_ready_o(readyW[2]), .tx_o(txW[2]), .tx_busy_o(busyW[2]), .tx_done_o(doneW[2])
    );

    // Unit 3: two stop bits
    uart_tx_ctrl #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u3 (
        .clk_i(clk), .rst_i(rst), .baud_tick_i(baudTick),
        .tx_data_i(dataW[3]), .tx_valid_i(validW[3]),
        .tx_ready_o(readyW[3]), .tx_o(txW[3]), .tx_busy_o(busyW[3]), .tx_done_o(doneW[3])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Baud tick: one clock high out of every 16, updated on the falling edge.
    initial begin
        tickCnt  = 0;
        baudTick = 1'b0;
        forever begin
            @(negedge clk);
            tickCnt  = (tickCnt == 15) ? 0 : tickCnt + 1;
            baudTick = (tickCnt == 15);
        end
    end

    // Safety net so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic nextCycle();
        @(negedge clk);
        #2;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Hands one word to unit u and follows the whole frame. expBits holds the
    // required line level for each bit period (bit 0 = start bit). Each period
    // must hold its level for all 16 clocks, tx_done must appear only in the
    // final clock of the last period, and ready must stay low throughout.
    // expWait < 0 skips the accept-to-start-bit latency check.
    task automatic applyStimulus(input int u, input logic [7:0] data,
                                 input logic [7:0] laterData, input bit holdValid,
                                 input int nBits, input logic [15:0] expBits,
                                 input int expWait, input string tag);
        int   waitCnt;
        int   bad;
        int   doneEarly;
        int   readyHigh;
        logic doneEnd;
        bit   lastSlot;

        checkOutput({tag, "_readyBefore"}, 32'(readyW[u]), 32'd1);
        dataW[u]  = data;
        validW[u] = 1'b1;
        nextCycle();
        dataW[u] = laterData;
        if (!holdValid) validW[u] = 1'b0;
        checkOutput({tag, "_busyAfterAccept"}, 32'(busyW[u]), 32'd1);

        waitCnt = 0;
        while (txW[u] !== 1'b0 && waitCnt < 64) begin
            nextCycle();
            waitCnt++;
        end
        checkOutput({tag, "_startFound"}, 32'(txW[u]), 32'd0);
        if (expWait >= 0) checkOutput({tag, "_startLatency"}, 32'(waitCnt), 32'(expWait));

        doneEarly = 0;
        readyHigh = 0;
        doneEnd   = 1'b0;
        for (int k = 0; k < nBits; k++) begin
            bad = 0;
            for (int c = 0; c < 16; c++) begin
                lastSlot = (k == nBits - 1) && (c == 15);
                if (txW[u] !== expBits[k]) bad++;
                if (readyW[u] !== 1'b0) readyHigh++;
                if (lastSlot) doneEnd = doneW[u];
                else if (doneW[u] !== 1'b0) doneEarly++;
                if (!lastSlot) nextCycle();
            end
            checkOutput($sformatf("%s_bit%0d_wrongClocks", tag, k), 32'(bad), 32'd0);
        end
        checkOutput({tag, "_doneAtEnd"}, 32'(doneEnd), 32'd1);
        checkOutput({tag, "_doneEarly"}, 32'(doneEarly), 32'd0);
        checkOutput({tag, "_readyDuringFrame"}, 32'(readyHigh), 32'd0);

        nextCycle();
        checkOutput({tag, "_busyAfter"}, 32'(busyW[u]), 32'd0);
        checkOutput({tag, "_readyAfter"}, 32'(readyW[u]), 32'd1);
        checkOutput({tag, "_txAfter"}, 32'(txW[u]), 32'd1);
        checkOutput({tag, "_doneAfter"}, 32'(doneW[u]), 32'd0);
    endtask

    initial begin
        int cnt;
        int doneCnt;

        testsRun    = 0;
        testsFailed = 0;
        rst         = 1'b1;
        for (int i = 0; i < 4; i++) begin
            validW[i] = 1'b0;
            dataW[i]  = 8'h00;
        end
        repeat (3) nextCycle();

        // Reset state
        checkOutput("rst_tx", 32'(txW[0]), 32'd1);
        checkOutput("rst_ready", 32'(readyW[0]), 32'd1);
        checkOutput("rst_busy", 32'(busyW[0]), 32'd0);
        checkOutput("rst_done", 32'(doneW[0]), 32'd0);
        checkOutput("rst_txStop2", 32'(txW[3]), 32'd1);
        rst = 1'b0;
        nextCycle();

        // 0xA5 8N1: periods 0,1,0,1,0,0,1,0,1,1 -> 10'b11_0100_1010.
        // tx_data changes to 0x00 right after the accept.
        applyStimulus(0, 8'hA5, 8'h00, 1'b0, 10, 16'h034A, -1, "basic");

        // 0x07 even parity: parity bit 1 -> 11'h60E; odd parity: 0 -> 11'h40E
        applyStimulus(1, 8'h07, 8'h00, 1'b0, 11, 16'h060E, -1, "parEven");
        applyStimulus(2, 8'h07, 8'h00, 1'b0, 11, 16'h040E, -1, "parOdd");

        // 0xFF with two stop bits: 11 periods, 32 clocks of stop -> 11'h7FE
        applyStimulus(3, 8'hFF, 8'h00, 1'b0, 11, 16'h07FE, -1, "stop2");

        // Back-to-back with valid held: 0x55 -> 10'h2AA, then 0x0F -> 10'h21E.
        // Second accept is the clock after tx_done; start bit falls at the
        // next tick, 15 sample windows after the accepting cycle.
        applyStimulus(0, 8'h55, 8'h0F, 1'b1, 10, 16'h02AA, -1, "b2bFirst");
        applyStimulus(0, 8'h0F, 8'h0F, 1'b0, 10, 16'h021E, 15, "b2bSecond");

        // Accept in a tick cycle: that tick is ignored, so tx stays high
        // 16 clocks and falls on the following tick. 0xC3 -> 10'h386.
        cnt = 0;
        while (baudTick !== 1'b1 && cnt < 32) begin
            nextCycle();
            cnt++;
        end
        checkOutput("syncToTick", 32'(baudTick), 32'd1);
        applyStimulus(0, 8'hC3, 8'h00, 1'b0, 10, 16'h0386, 16, "tickAccept");

        // Reset in the middle of data bit 3 of 0xA5 (that bit is 0)
        dataW[0]  = 8'hA5;
        validW[0] = 1'b1;
        nextCycle();
        validW[0] = 1'b0;
        cnt = 0;
        while (txW[0] !== 1'b0 && cnt < 64) begin
            nextCycle();
            cnt++;
        end
        checkOutput("midRst_startFound", 32'(txW[0]), 32'd0);
        repeat (72) nextCycle();
        checkOutput("midRst_txBeforeRst", 32'(txW[0]), 32'd0);
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
        checkOutput("midRst_tx", 32'(txW[0]), 32'd1);
        checkOutput("midRst_ready", 32'(readyW[0]), 32'd1);
        checkOutput("midRst_busy", 32'(busyW[0]), 32'd0);
        checkOutput("midRst_done", 32'(doneW[0]), 32'd0);
        doneCnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (doneW[0] !== 1'b0) doneCnt++;
            nextCycle();
        end
        checkOutput("midRst_noLateDone", 32'(doneCnt), 32'd0);
        checkOutput("midRst_txIdle", 32'(txW[0]), 32'd1);

        // Clean frame after the abort: 0x3C -> 10'h278
        applyStimulus(0, 8'h3C, 8'h00, 1'b0, 10, 16'h0278, -1, "postRst");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
